// File: rtl/cpu_pkg.sv
// Shared CPU definitions: func3 access encodings, common constants and the
// data-memory controller state type.
package cpu_pkg;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b000;
   localparam logic [2:0] OP_SH  = 3'b001;
   localparam logic [2:0] OP_SW  = 3'b010;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   localparam int WstrbWidth = 4;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'b00,
      DMEM_REQ  = 2'b01,
      DMEM_RESP = 2'b10,
      DMEM_DONE = 2'b11
   } dmem_state_e;

   // Unknown encodings fall back to a full-word access.
   function automatic logic [1:0] access_size(input logic [2:0] func3);
      logic [1:0] size;
      case (func3[1:0])
         2'b00:   size = SIZE_BYTE;
         2'b01:   size = SIZE_HALF;
         default: size = SIZE_WORD;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/dmem_fmt.sv
// Combinational access formatter: byte strobes, misalignment check and
// load-data extraction with sign/zero extension.
module dmem_fmt
   import cpu_pkg::*;
#(
   parameter int DataWidth = 32
) (
   input  logic [2:0]            func3,
   input  logic [1:0]            addr_lo,
   input  logic [DataWidth-1:0]  word,
   output logic [WstrbWidth-1:0] wstrb,
   output logic                  misalign,
   output logic [DataWidth-1:0]  load_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Strobe pattern and alignment rule follow the access size.
   always_comb begin
      wstrb    = 4'b0000;
      misalign = 1'b0;
      case (access_size(func3))
         SIZE_BYTE: begin
            wstrb    = 4'b0001 << addr_lo;
            misalign = 1'b0;
         end
         SIZE_HALF: begin
            wstrb    = 4'b0011 << {addr_lo[1], 1'b0};
            misalign = addr_lo[0];
         end
         default: begin
            wstrb    = 4'b1111;
            misalign = (addr_lo != 2'b00);
         end
      endcase
   end

   // Lane selection then extension of the raw bus word.
   always_comb begin
      case (addr_lo)
         2'b00:   byte_s = word[7:0];
         2'b01:   byte_s = word[15:8];
         2'b10:   byte_s = word[23:16];
         2'b11:   byte_s = word[31:24];
         default: byte_s = word[7:0];
      endcase
      if (addr_lo[1]) begin
         half_s = word[31:16];
      end else begin
         half_s = word[15:0];
      end
      case (func3)
         OP_LB:   load_data = {{(DataWidth-8){byte_s[7]}}, byte_s};
         OP_LH:   load_data = {{(DataWidth-16){half_s[15]}}, half_s};
         OP_LBU:  load_data = {{(DataWidth-8){1'b0}}, byte_s};
         OP_LHU:  load_data = {{(DataWidth-16){1'b0}}, half_s};
         default: load_data = word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one load/store per instruction over a
// valid/ready request plus response wait, with pipeline stall and error flags.
module dmem_ctrl
   import cpu_pkg::*;
#(
   parameter int AddrWidth   = 32,
   parameter int DataWidth   = 32,
   parameter int RespTimeout = 255
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  data_read_i,
   input  logic                  data_write_i,
   input  logic [2:0]            func3_i,
   input  logic [AddrWidth-1:0]  data_addr_i,
   input  logic [DataWidth-1:0]  data_wdata_i,
   output logic                  stall_o,
   output logic [DataWidth-1:0]  rdata_o,
   output logic                  rdata_valid_o,
   output logic                  misalign_o,
   output logic                  bus_err_o,
   output logic                  req_valid_o,
   input  logic                  req_ready_i,
   output logic                  req_write_o,
   output logic [AddrWidth-1:0]  req_addr_o,
   output logic [WstrbWidth-1:0] req_wstrb_o,
   output logic [DataWidth-1:0]  req_wdata_o,
   input  logic                  resp_valid_i,
   input  logic [DataWidth-1:0]  resp_data_i,
   input  logic                  resp_err_i
);

   localparam int CntWidth = (RespTimeout < 1) ? 1 : $clog2(RespTimeout + 1);

   dmem_state_e           state_r;
   logic [2:0]            func3_r;
   logic [1:0]            addr_lo_r;
   logic                  write_r;
   logic [CntWidth-1:0]   cnt_r;
   logic                  req_valid_r;
   logic [AddrWidth-1:0]  req_addr_r;
   logic [WstrbWidth-1:0] req_wstrb_r;
   logic [DataWidth-1:0]  req_wdata_r;
   logic [DataWidth-1:0]  rdata_r;
   logic                  rdata_valid_r;
   logic                  bus_err_r;

   logic [WstrbWidth-1:0] req_wstrb_s;
   logic                  req_misalign_s;
   logic [DataWidth-1:0]  req_load_s;
   logic [WstrbWidth-1:0] rsp_wstrb_s;
   logic                  rsp_misalign_s;
   logic [DataWidth-1:0]  rsp_load_s;
   logic                  one_req_s;
   logic                  start_s;
   logic                  stall_s;
   logic                  unused_s;

   dmem_fmt #(.DataWidth(DataWidth)) u_req_fmt (
      .func3     (func3_i),
      .addr_lo   (data_addr_i[1:0]),
      .word      (ZeroWord),
      .wstrb     (req_wstrb_s),
      .misalign  (req_misalign_s),
      .load_data (req_load_s)
   );

   dmem_fmt #(.DataWidth(DataWidth)) u_rsp_fmt (
      .func3     (func3_r),
      .addr_lo   (addr_lo_r),
      .word      (resp_data_i),
      .wstrb     (rsp_wstrb_s),
      .misalign  (rsp_misalign_s),
      .load_data (rsp_load_s)
   );

   assign unused_s  = ^{req_load_s, rsp_wstrb_s, rsp_misalign_s};
   assign one_req_s = data_read_i ^ data_write_i;
   assign start_s   = (state_r == DMEM_IDLE) && one_req_s && !req_misalign_s;

   // Stall covers the accepting IDLE cycle and the whole bus wait.
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         DMEM_IDLE: stall_s = start_s;
         DMEM_REQ:  stall_s = 1'b1;
         DMEM_RESP: stall_s = 1'b1;
         DMEM_DONE: stall_s = 1'b0;
         default:   stall_s = 1'b0;
      endcase
   end

   assign stall_o       = stall_s;
   assign misalign_o    = (state_r == DMEM_IDLE) && one_req_s && req_misalign_s;
   assign req_valid_o   = req_valid_r;
   assign req_write_o   = write_r;
   assign req_addr_o    = req_addr_r;
   assign req_wstrb_o   = req_wstrb_r;
   assign req_wdata_o   = req_wdata_r;
   assign rdata_o       = rdata_r;
   assign rdata_valid_o = rdata_valid_r;
   assign bus_err_o     = bus_err_r;

   // Transaction FSM with registered bus payload and result pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= DMEM_IDLE;
         func3_r       <= 3'b000;
         addr_lo_r     <= 2'b00;
         write_r       <= 1'b0;
         cnt_r         <= {CntWidth{1'b0}};
         req_valid_r   <= 1'b0;
         req_addr_r    <= {AddrWidth{1'b0}};
         req_wstrb_r   <= {WstrbWidth{1'b0}};
         req_wdata_r   <= {DataWidth{1'b0}};
         rdata_r       <= {DataWidth{1'b0}};
         rdata_valid_r <= 1'b0;
         bus_err_r     <= 1'b0;
      end else begin
         case (state_r)
            DMEM_IDLE: begin
               if (start_s) begin
                  state_r     <= DMEM_REQ;
                  req_valid_r <= 1'b1;
                  write_r     <= data_write_i;
                  func3_r     <= func3_i;
                  addr_lo_r   <= data_addr_i[1:0];
                  req_addr_r  <= {data_addr_i[AddrWidth-1:2], 2'b00};
                  req_wstrb_r <= data_write_i ? req_wstrb_s : {WstrbWidth{1'b0}};
                  req_wdata_r <= data_write_i ? data_wdata_i : ZeroWord;
               end
            end
            DMEM_REQ: begin
               if (req_ready_i) begin
                  state_r     <= DMEM_RESP;
                  req_valid_r <= 1'b0;
                  cnt_r       <= {CntWidth{1'b0}};
               end
            end
            DMEM_RESP: begin
               if (resp_valid_i) begin
                  state_r       <= DMEM_DONE;
                  rdata_valid_r <= !write_r;
                  bus_err_r     <= resp_err_i;
                  if (!write_r) begin
                     rdata_r <= resp_err_i ? ZeroWord : rsp_load_s;
                  end
               end else if (cnt_r == CntWidth'(RespTimeout)) begin
                  state_r       <= DMEM_DONE;
                  rdata_valid_r <= !write_r;
                  bus_err_r     <= 1'b1;
                  if (!write_r) begin
                     rdata_r <= ZeroWord;
                  end
               end else begin
                  cnt_r <= cnt_r + CntWidth'(1);
               end
            end
            DMEM_DONE: begin
               // The MEM request still visible here is the finished one.
               state_r       <= DMEM_IDLE;
               rdata_valid_r <= 1'b0;
               bus_err_r     <= 1'b0;
            end
            default: begin
               state_r       <= DMEM_IDLE;
               req_valid_r   <= 1'b0;
               rdata_valid_r <= 1'b0;
               bus_err_r     <= 1'b0;
            end
         endcase
      end
   end

endmodule
